// File: rtl/mod12_count_monitor.sv
// Receive-side monitor for a mod-MOD up/down count bus. It locks onto a run of legal +/-1 steps
// and reports direction, wraps, illegal steps and out-of-range samples. All outputs are registered one clock after the sample.
module mod12_count_monitor #(
  parameter int MOD      = 12,
  parameter int LOCK_LEN = 3,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              Strobe,
  input  logic [3:0]        CountIn,
  output logic              Locked,
  output logic              Dir,
  output logic              WrapUp,
  output logic              WrapDown,
  output logic              StepErr,
  output logic              RangeErr,
  output logic [WRAP_W-1:0] WrapCount,
  output logic [ERR_W-1:0]  ErrCount
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [4:0] MOD_V      = 5'(MOD);
  localparam logic [3:0] MAX_V      = 4'(MOD - 1);
  localparam logic [3:0] LOCK_V     = 4'(LOCK_LEN);
  localparam logic [3:0] LOCK_LAST  = 4'(LOCK_LEN - 1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);

  state_t     state;
  logic [3:0] prev;
  logic       prev_valid;
  logic [3:0] run;

  logic       in_range;
  logic [3:0] prev_inc;
  logic [3:0] prev_dec;
  logic       step_up;
  logic       step_down;
  logic       legal;
  logic       err_evt;

  assign in_range  = ({1'b0, CountIn} < MOD_V);
  assign prev_inc  = (prev == MAX_V) ? 4'd0 : prev + 4'd1;
  assign prev_dec  = (prev == 4'd0) ? MAX_V : prev - 4'd1;
  assign step_up   = in_range && prev_valid && (CountIn == prev_inc);
  assign step_down = in_range && prev_valid && (CountIn == prev_dec);
  assign legal     = step_up || step_down;
  // At most one error per sample: a range error suppresses any step error.
  assign err_evt   = Strobe && (!in_range || (state == LOCKED && !legal));

  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= HUNT;
      prev       <= 4'd0;
      prev_valid <= 1'b0;
      run        <= 4'd0;
      Locked     <= 1'b0;
      Dir        <= 1'b0;
      WrapUp     <= 1'b0;
      WrapDown   <= 1'b0;
      StepErr    <= 1'b0;
      RangeErr   <= 1'b0;
      WrapCount  <= '0;
      ErrCount   <= '0;
    end else begin
      WrapUp   <= 1'b0;
      WrapDown <= 1'b0;
      StepErr  <= 1'b0;
      RangeErr <= 1'b0;
      if (Strobe) begin
        if (!in_range) begin
          RangeErr   <= 1'b1;
          run        <= 4'd0;
          prev_valid <= 1'b0;
          state      <= HUNT;
          Locked     <= 1'b0;
        end else if (!prev_valid) begin
          prev       <= CountIn;
          prev_valid <= 1'b1;
          run        <= 4'd0;
        end else if (legal) begin
          prev <= CountIn;
          Dir  <= step_up;
          if (state == LOCKED) begin
            if (step_up && CountIn == 4'd0) begin
              WrapUp    <= 1'b1;
              WrapCount <= WrapCount + WRAP_ONE;
            end
            if (step_down && CountIn == MAX_V) begin
              WrapDown  <= 1'b1;
              WrapCount <= WrapCount - WRAP_ONE;
            end
          end else if (run == LOCK_LAST) begin
            // The locking step is judged in HUNT, so it never produces a wrap pulse.
            state  <= LOCKED;
            Locked <= 1'b1;
            run    <= LOCK_V;
          end else begin
            run <= run + 4'd1;
          end
        end else begin
          prev <= CountIn;
          run  <= 4'd0;
          if (state == LOCKED) begin
            StepErr <= 1'b1;
            state   <= HUNT;
            Locked  <= 1'b0;
          end
        end
        if (err_evt && ErrCount != '1)
          ErrCount <= ErrCount + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mod12_count_monitor.sv
// Directed test-plan sequences plus randomized traffic, checked every cycle against an integer reference model.
module tb_mod12_count_monitor;

  localparam int MOD = 12;
  localparam int LOCK_LEN = 3;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       Strobe = 1'b0;
  logic [3:0] CountIn = 4'd0;
  logic       Locked, Dir, WrapUp, WrapDown, StepErr, RangeErr;
  logic [7:0] WrapCount, ErrCount;

  mod12_count_monitor #(.MOD(MOD), .LOCK_LEN(LOCK_LEN), .WRAP_W(8), .ERR_W(8)) dut (
    .Clk(Clk), .reset(reset), .Strobe(Strobe), .CountIn(CountIn),
    .Locked(Locked), .Dir(Dir), .WrapUp(WrapUp), .WrapDown(WrapDown),
    .StepErr(StepErr), .RangeErr(RangeErr), .WrapCount(WrapCount), .ErrCount(ErrCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // reference model: tracked at the level of "last seen value" and "legal steps so far"
  bit m_locked, m_has_prev, m_dir;
  int m_prev, m_run, m_wraps, m_errs;
  bit m_wu, m_wd, m_se, m_re;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit s, input int v);
    bit up, dn;
    if (r) begin
      m_locked = 0; m_has_prev = 0; m_dir = 0; m_prev = 0; m_run = 0;
      m_wraps = 0; m_errs = 0; m_wu = 0; m_wd = 0; m_se = 0; m_re = 0;
      return;
    end
    m_wu = 0; m_wd = 0; m_se = 0; m_re = 0;
    if (!s) return;
    if (v >= MOD) begin
      m_re = 1; m_run = 0; m_has_prev = 0; m_locked = 0;
    end else if (!m_has_prev) begin
      m_prev = v; m_has_prev = 1; m_run = 0;
    end else begin
      up = (v == (m_prev + 1) % MOD);
      dn = (v == (m_prev + MOD - 1) % MOD);
      if (up || dn) begin
        m_dir = up;
        if (m_locked) begin
          m_wu = up && (m_prev == MOD - 1);
          m_wd = dn && (m_prev == 0);
          m_wraps = m_wraps + (m_wu ? 1 : 0) - (m_wd ? 1 : 0);
        end else begin
          m_run++;
          if (m_run >= LOCK_LEN) m_locked = 1;
        end
      end else begin
        m_se = m_locked;
        m_locked = 0; m_run = 0;
      end
      m_prev = v;
    end
    if ((m_re || m_se) && m_errs < 255) m_errs++;
  endtask

  // one clock: drive, let the edge happen, advance the model, compare away from the edge
  task automatic cyc(input bit r, input bit s, input int v);
    reset = r; Strobe = s; CountIn = 4'(v);
    @(posedge Clk);
    model(r, s, v);
    #1;
    chk("locked",   int'(Locked),   int'(m_locked));
    chk("dir",      int'(Dir),      int'(m_dir));
    chk("wrap_up",  int'(WrapUp),   int'(m_wu));
    chk("wrap_dn",  int'(WrapDown), int'(m_wd));
    chk("step_err", int'(StepErr),  int'(m_se));
    chk("rng_err",  int'(RangeErr), int'(m_re));
    chk("wrap_cnt", int'(WrapCount), m_wraps & 8'hFF);
    chk("err_cnt",  int'(ErrCount), m_errs);
  endtask

  task automatic smp(input int v);
    cyc(1'b0, 1'b1, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, r;
    bit s;
    #1;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("lit_reset_locked", int'(Locked), 0);
    chk("lit_reset_errcnt", int'(ErrCount), 0);

    // lock up on 5,6,7,8
    smp(5); smp(6); smp(7);
    chk("lit_not_locked_yet", int'(Locked), 0);
    smp(8);
    chk("lit_locked", int'(Locked), 1);
    chk("lit_dir_up", int'(Dir), 1);

    // wraps both ways
    smp(9); smp(10); smp(11); smp(0);
    chk("lit_wrap_up", int'(WrapUp), 1);
    chk("lit_wrapcnt_1", int'(WrapCount), 1);
    smp(1); smp(0);
    chk("lit_dir_down", int'(Dir), 0);
    smp(11);
    chk("lit_wrap_dn", int'(WrapDown), 1);
    chk("lit_wrapcnt_0", int'(WrapCount), 0);
    smp(10);

    // repeated value is a step error; relock in HUNT never wraps
    smp(10);
    chk("lit_step_err", int'(StepErr), 1);
    chk("lit_unlock_step", int'(Locked), 0);
    chk("lit_errcnt_1", int'(ErrCount), 1);
    smp(11); smp(0); smp(1);
    chk("lit_relock", int'(Locked), 1);
    chk("lit_no_hunt_wrap", int'(WrapCount), 0);

    // range error, then 2 only reseeds
    smp(13);
    chk("lit_range_err", int'(RangeErr), 1);
    chk("lit_range_no_step", int'(StepErr), 0);
    chk("lit_errcnt_2", int'(ErrCount), 2);
    smp(2); smp(3); smp(4);
    chk("lit_no_lock_234", int'(Locked), 0);
    smp(5);
    chk("lit_lock_5", int'(Locked), 1);

    // strobe gaps on a legal stream, wrap pulse lasts one clock
    for (int v = 6; v <= 12; v++) begin
      smp(v % MOD);
      cyc(0, 0, 15);
    end
    chk("lit_gap_wrap_gone", int'(WrapUp), 0);
    chk("lit_gap_locked", int'(Locked), 1);
    chk("lit_gap_wrapcnt", int'(WrapCount), 1);

    // saturation
    for (int i = 0; i < 300; i++) smp(12 + (i % 4));
    chk("lit_err_sat", int'(ErrCount), 255);

    // reset mid-lock with WrapCount=5
    cyc(1, 0, 0);
    smp(0); smp(1); smp(2); smp(3);
    for (int i = 4; i <= 60; i++) smp(i % MOD);
    chk("lit_wrapcnt_5", int'(WrapCount), 5);
    cyc(1, 1, 7);
    chk("lit_rst_locked", int'(Locked), 0);
    chk("lit_rst_wrapcnt", int'(WrapCount), 0);
    smp(8); smp(9); smp(10);
    chk("lit_rst_seed_only", int'(Locked), 0);
    smp(11);
    chk("lit_rst_relock", int'(Locked), 1);

    // randomized traffic: mostly legal steps, some glitches, gaps and resets
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      s = ($urandom_range(0, 3) != 0);
      if (r < 2) cyc(1, s, cur);
      else begin
        if (s) begin
          if (r < 80) cur = (cur + (($urandom_range(0, 4) == 0) ? MOD - 1 : 1)) % MOD;
          else if (r < 92) cur = $urandom_range(0, MOD - 1);
          else cur = $urandom_range(0, 15);
        end
        cyc(0, s, cur);
        if (cur >= MOD) cur = $urandom_range(0, MOD - 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
